// File: rtl/bcd_unpack_pkg.sv
// Shared constants and types for the bcd_unpack BCD-to-binary converter.
// State codes, digit adjust constants and the minimum output width helper.
package bcd_unpack_pkg;

    localparam logic [1:0] BCDU_IDLE  = 2'd0;
    localparam logic [1:0] BCDU_SHIFT = 2'd1;
    localparam logic [1:0] BCDU_DONE  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = BCDU_IDLE,
        ST_SHIFT = BCDU_SHIFT,
        ST_DONE  = BCDU_DONE
    } state_t;

    localparam logic [3:0] DIG_MAX    = 4'd9;
    localparam logic [3:0] ADJ_THRESH = 4'd8;
    localparam logic [3:0] ADJ_VAL    = 4'd3;

    // Smallest width w with 2**w >= 10**digits.
    function automatic int bcdu_min_width(input int digits);
        longint unsigned lim;
        int w;
        lim = 64'd1;
        for (int i = 0; i < digits; i++) begin
            lim = lim * 64'd10;
        end
        w = 0;
        while ((64'd1 << w) < lim) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit of the reverse double-dabble step: subtract 3 when the
// digit is 8 or more, and flag digits above 9 as invalid BCD.
module bcd_digit_adj
    import bcd_unpack_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] adj,
    output logic       invalid
);

    assign adj     = (digit >= ADJ_THRESH) ? digit - ADJ_VAL : digit;
    assign invalid = (digit > DIG_MAX);

endmodule

// File: rtl/bcd_unpack.sv
// Multi-cycle packed-BCD to binary converter, one reverse double-dabble
// iteration per clock, with valid/ready handshakes on both sides.
module bcd_unpack
    import bcd_unpack_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int OUT_W  = 14
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_bcd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_W-1:0]      out_bin,
    output logic                  out_err,
    output logic                  busy
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(OUT_W + 1);

    if (OUT_W < bcdu_min_width(DIGITS)) begin : g_bad_width
        $error("bcd_unpack: OUT_W too small for DIGITS");
    end

    state_t            state;
    state_t            state_nx;
    logic [BW-1:0]     bcd_reg;
    logic [OUT_W-1:0]  bin;
    logic              err;
    logic [CW-1:0]     cnt;

    logic [BW-1:0]     shifted;
    logic [BW-1:0]     dig_src;
    logic [BW-1:0]     adj_bcd;
    logic [DIGITS-1:0] dig_bad;
    logic              any_bad;
    logic              accept;
    logic              last;

    assign shifted = {1'b0, bcd_reg[BW-1:1]};

    // The digit cells validate the input while idle and adjust otherwise.
    assign dig_src = (state == ST_IDLE) ? in_bcd : shifted;

    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        bcd_digit_adj u_adj (
            .digit   (dig_src[4*i +: 4]),
            .adj     (adj_bcd[4*i +: 4]),
            .invalid (dig_bad[i])
        );
    end

    assign any_bad   = |dig_bad;
    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state == ST_SHIFT);
    assign accept    = in_valid && in_ready;
    assign last      = (cnt == CW'(OUT_W - 1));
    assign out_bin   = bin;
    assign out_err   = err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nx = any_bad ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (last) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bcd_reg <= '0;
            bin     <= '0;
            err     <= 1'b0;
            cnt     <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        bin <= '0;
                        cnt <= '0;
                        err <= any_bad;
                        if (!any_bad) begin
                            bcd_reg <= in_bcd;
                        end
                    end
                end
                ST_SHIFT: begin
                    bcd_reg <= adj_bcd;
                    bin     <= {bcd_reg[0], bin[OUT_W-1:1]};
                    cnt     <= cnt + CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_unpack.sv
// Bench for bcd_unpack: a 4-digit and a 2-digit instance checked every
// cycle against a transaction-level decimal model, plus directed cases.
module tb_bcd_unpack;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [1:0]        ivalid;
    logic [1:0]        oready;
    logic [1:0][15:0]  ibcd;
    logic [1:0]        iready;
    logic [1:0]        ovalid;
    logic [1:0]        obusy;
    logic [1:0]        oerr;
    logic [13:0]       obin4;
    logic [6:0]        obin2;

    int vectors = 0;
    int miscompares = 0;

    bit m_busy [2];
    bit m_valid [2];
    bit m_err [2];
    int m_left [2];
    int m_bin [2];

    initial forever #5 clk = ~clk;

    bcd_unpack #(.DIGITS(4), .OUT_W(14)) u_dut4 (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (ivalid[0]),
        .in_ready  (iready[0]),
        .in_bcd    (ibcd[0]),
        .out_valid (ovalid[0]),
        .out_ready (oready[0]),
        .out_bin   (obin4),
        .out_err   (oerr[0]),
        .busy      (obusy[0])
    );

    bcd_unpack #(.DIGITS(2), .OUT_W(7)) u_dut2 (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (ivalid[1]),
        .in_ready  (iready[1]),
        .in_bcd    (ibcd[1][7:0]),
        .out_valid (ovalid[1]),
        .out_ready (oready[1]),
        .out_bin   (obin2),
        .out_err   (oerr[1]),
        .busy      (obusy[1])
    );

    function automatic int nd_of(input int id);
        return (id == 0) ? 4 : 2;
    endfunction

    function automatic int ow_of(input int id);
        return (id == 0) ? 14 : 7;
    endfunction

    function automatic int bin_of(input int id);
        return (id == 0) ? int'(obin4) : int'(obin2);
    endfunction

    // Decimal value of the packed digits; any digit above 9 is an error.
    task automatic ref_conv(input logic [15:0] bcd, input int nd,
                            output int v, output bit e);
        int d;
        v = 0;
        e = 1'b0;
        for (int i = nd - 1; i >= 0; i--) begin
            d = int'(bcd[4*i +: 4]);
            if (d > 9) e = 1'b1;
            v = v * 10 + d;
        end
        if (e) v = 0;
    endtask

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic m_clear(input int id);
        m_busy[id]  = 1'b0;
        m_valid[id] = 1'b0;
        m_err[id]   = 1'b0;
        m_left[id]  = 0;
        m_bin[id]   = 0;
    endtask

    task automatic m_advance(input int id);
        int v;
        bit e;
        if (m_valid[id]) begin
            if (oready[id]) m_valid[id] = 1'b0;
        end else if (m_busy[id]) begin
            m_left[id]--;
            if (m_left[id] == 0) begin
                m_busy[id]  = 1'b0;
                m_valid[id] = 1'b1;
            end
        end else if (ivalid[id]) begin
            ref_conv(ibcd[id], nd_of(id), v, e);
            m_bin[id] = v;
            m_err[id] = e;
            if (e) begin
                m_valid[id] = 1'b1;
            end else begin
                m_busy[id] = 1'b1;
                m_left[id] = ow_of(id);
            end
        end
    endtask

    task automatic m_compare(input int id);
        string p;
        p = $sformatf("dut%0d", id);
        check({p, " in_ready"}, int'(iready[id]),
              int'(!(m_busy[id] || m_valid[id])));
        check({p, " out_valid"}, int'(ovalid[id]), int'(m_valid[id]));
        check({p, " busy"}, int'(obusy[id]), int'(m_busy[id]));
        if (m_valid[id]) begin
            check({p, " out_bin"}, bin_of(id), m_bin[id]);
            check({p, " out_err"}, int'(oerr[id]), int'(m_err[id]));
        end
        if (!reset_n) begin
            check({p, " rst out_bin"}, bin_of(id), 0);
            check({p, " rst out_err"}, int'(oerr[id]), 0);
        end
    endtask

    // Compare process: model steps on each rising edge, checks at falling.
    initial begin
        forever begin
            @(posedge clk);
            for (int id = 0; id < 2; id++) begin
                if (reset_n) m_advance(id);
                else m_clear(id);
            end
            @(negedge clk);
            for (int id = 0; id < 2; id++) begin
                if (!reset_n) m_clear(id);
                m_compare(id);
            end
        end
    end

    function automatic logic [15:0] rand_bcd(input int nd);
        logic [15:0] v;
        int d;
        v = '0;
        for (int i = 0; i < nd; i++) begin
            if ($urandom_range(9, 0) == 0) d = int'($urandom_range(15, 10));
            else d = int'($urandom_range(9, 0));
            v[4*i +: 4] = d[3:0];
        end
        return v;
    endfunction

    task automatic send(input int id, input logic [15:0] bcd, input int bp,
                        input int exp_v, input bit exp_e, input int exp_lat);
        int guard;
        int lat;
        string p;
        p = $sformatf("dut%0d %h", id, bcd);
        guard = 0;
        while (!iready[id] && guard < 50) begin
            @(posedge clk); #2;
            guard++;
        end
        check({p, " idle before send"}, int'(iready[id]), 1);
        ivalid[id] = 1'b1;
        ibcd[id]   = bcd;
        oready[id] = (bp == 0);
        @(posedge clk); #2;
        if (bp == 0) ivalid[id] = 1'b0;
        check({p, " in_ready low after accept"}, int'(iready[id]), 0);
        lat = 0;
        while (!ovalid[id] && lat < 40) begin
            @(posedge clk); #2;
            lat++;
        end
        check({p, " latency"}, lat, exp_lat);
        check({p, " out_bin"}, bin_of(id), exp_v);
        check({p, " out_err"}, int'(oerr[id]), int'(exp_e));
        for (int k = 0; k < bp; k++) begin
            @(posedge clk); #2;
            check({p, " held out_valid"}, int'(ovalid[id]), 1);
            check({p, " held out_bin"}, bin_of(id), exp_v);
            check({p, " no accept in DONE"}, int'(iready[id]), 0);
        end
        oready[id] = 1'b1;
        @(posedge clk); #2;
        ivalid[id] = 1'b0;
        check({p, " in_ready after handoff"}, int'(iready[id]), 1);
        check({p, " out_valid after handoff"}, int'(ovalid[id]), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ivalid = '0;
        oready = '1;
        ibcd   = '0;
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b1;
        for (int id = 0; id < 2; id++) begin
            check($sformatf("dut%0d reset in_ready", id), int'(iready[id]), 1);
            check($sformatf("dut%0d reset out_valid", id), int'(ovalid[id]), 0);
            check($sformatf("dut%0d reset busy", id), int'(obusy[id]), 0);
            check($sformatf("dut%0d reset out_bin", id), bin_of(id), 0);
        end

        send(0, 16'h9999, 0, 9999, 1'b0, 14);
        send(0, 16'h0000, 0, 0, 1'b0, 14);
        send(0, 16'h0010, 0, 10, 1'b0, 14);
        send(0, 16'h1234, 0, 1234, 1'b0, 14);
        send(0, 16'h1A00, 0, 0, 1'b1, 0);
        send(0, 16'h000F, 0, 0, 1'b1, 0);
        send(0, 16'h0042, 5, 42, 1'b0, 14);

        // Abort a conversion part-way with an asynchronous reset.
        ivalid[0] = 1'b1;
        ibcd[0]   = 16'h5555;
        @(posedge clk); #2;
        ivalid[0] = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        check("reset abort busy before", int'(obusy[0]), 1);
        reset_n = 1'b0;
        #1;
        check("reset abort in_ready", int'(iready[0]), 1);
        check("reset abort out_valid", int'(ovalid[0]), 0);
        check("reset abort busy", int'(obusy[0]), 0);
        check("reset abort out_bin", bin_of(0), 0);
        @(posedge clk); #2;
        reset_n = 1'b1;
        send(0, 16'h0007, 0, 7, 1'b0, 14);

        send(1, 16'h0099, 0, 99, 1'b0, 7);
        send(1, 16'h0015, 0, 15, 1'b0, 7);
        send(1, 16'h009A, 0, 0, 1'b1, 0);

        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #2;
            for (int id = 0; id < 2; id++) begin
                ivalid[id] = ($urandom_range(2, 0) == 0);
                ibcd[id]   = rand_bcd(nd_of(id));
                oready[id] = ($urandom_range(3, 0) != 0);
            end
        end
        ivalid = '0;
        oready = '1;
        repeat (20) @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
